// File: rtl/dds_noise_pkg.sv
// Shared types and constants for the DDS noise voice sequencer.
package dds_noise_pkg;
   typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

   localparam int NOISE_N     = 14;
   localparam int NOISE_M     = 12;
   localparam int NOISE_DIV_W = 16;

   localparam logic [NOISE_N-1:0] NOISE_LOCKUP = {NOISE_N{1'b1}};

   localparam int NOISE_TAP0 = NOISE_N - 1;
   localparam int NOISE_TAP1 = NOISE_N - 2;
   localparam int NOISE_TAP2 = NOISE_N - 3;
   localparam int NOISE_TAP3 = 1;
endpackage

// File: rtl/noise_lfsr_core.sv
// XNOR LFSR with load/step enables and all-ones guard; state updates one cycle after the enable.
// No backpressure: load and step are taken unconditionally when asserted.
module noise_lfsr_core
   import dds_noise_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               load,
   input  logic [NOISE_N-1:0] load_val,
   input  logic               step,
   output logic [NOISE_M-1:0] sample_nxt,
   output logic               lockup
);
   logic [NOISE_N-1:0] shift;
   logic [NOISE_N-1:0] cand;
   logic [NOISE_N-1:0] shift_nxt;
   logic               fb;
   logic               hit;

   // Load and step share the guard so a seed of all-ones also recovers to zero.
   always_comb begin
      fb         = shift[NOISE_TAP0] ~^ shift[NOISE_TAP1] ~^ shift[NOISE_TAP2] ~^ shift[NOISE_TAP3];
      cand       = load ? load_val : {shift[NOISE_N-2:0], fb};
      hit        = (load || step) && (cand == NOISE_LOCKUP);
      shift_nxt  = hit ? '0 : cand;
      sample_nxt = shift_nxt[NOISE_N-1:NOISE_N-NOISE_M];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shift  <= '0;
         lockup <= 1'b0;
      end else begin
         lockup <= hit;
         if (load || step)
            shift <= shift_nxt;
      end
   end
endmodule

// File: rtl/noise_sched.sv
// Noise voice sequencer: LFSR stepped every rate+1 cycles, 1-deep valid/ready sample slot; seed visible 2 cycles after seed_load.
// Steps while the slot is full and unaccepted drop the sample; NOISE_SCHED_OVERRUN_CNT_EN adds overrun_cnt.
module noise_sched
   import dds_noise_pkg::*;
#(
   parameter int N     = NOISE_N,
   parameter int M     = NOISE_M,
   parameter int DIV_W = NOISE_DIV_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             seed_load,
   input  logic [N-1:0]     seed,
   input  logic [DIV_W-1:0] rate,
   input  logic             out_ready,
   output logic             out_valid,
   output logic [M-1:0]     noise,
   output logic             lockup,
   output logic             busy
`ifdef NOISE_SCHED_OVERRUN_CNT_EN
   ,
   output logic [7:0]       overrun_cnt
`endif
);
   state_t             state;
   state_t             state_nxt;
   logic [DIV_W-1:0]   div;
   logic [N-1:0]       seed_q;
   logic [M-1:0]       sample_nxt;
   logic               step;
   logic               ld;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // seed_load wins over everything, including a step due this cycle.
   always_comb begin
      state_nxt = state;
      busy      = (state != IDLE);
      ld        = (state == LOAD);
      step      = (state == RUN) && en && !seed_load && (div == '0);
      if (seed_load)
         state_nxt = LOAD;
      else begin
         case (state)
            IDLE:    if (en) state_nxt = RUN;
            LOAD:    state_nxt = en ? RUN : IDLE;
            RUN:     if (!en) state_nxt = IDLE;
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div    <= '0;
         seed_q <= '0;
      end else begin
         if (seed_load)
            seed_q <= seed;
         else if ((state == IDLE && en) || state == LOAD)
            div <= rate;
         else if (state == RUN && en)
            div <= (div == '0) ? rate : div - 1'b1;
      end
   end

   noise_lfsr_core u_lfsr (
      .clk        (clk),
      .rst_n      (rst_n),
      .load       (ld),
      .load_val   (seed_q),
      .step       (step),
      .sample_nxt (sample_nxt),
      .lockup     (lockup)
   );

   // A step may refill the slot in the same cycle the mixer drains it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         noise     <= '0;
      end else if (step && (!out_valid || out_ready)) begin
         out_valid <= 1'b1;
         noise     <= sample_nxt;
      end else if (out_valid && out_ready) begin
         out_valid <= 1'b0;
      end
   end

`ifdef NOISE_SCHED_OVERRUN_CNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         overrun_cnt <= '0;
      else if (seed_load)
         overrun_cnt <= '0;
      else if (step && out_valid && !out_ready && overrun_cnt != 8'hFF)
         overrun_cnt <= overrun_cnt + 8'd1;
   end
`endif
endmodule

// File: tb/tb_noise_sched.sv
// Directed bench for noise_sched; build with NOISE_SCHED_OVERRUN_CNT_EN to cover the overrun counter.
module tb_noise_sched;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        en;
   logic        seed_load;
   logic [13:0] seed;
   logic [15:0] rate;
   logic        out_ready;
   logic        out_valid;
   logic [11:0] noise;
   logic        lockup;
   logic        busy;
`ifdef NOISE_SCHED_OVERRUN_CNT_EN
   logic [7:0]  overrun_cnt;
`endif

   int checks = 0;
   int errors = 0;

   noise_sched dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .en          (en),
      .seed_load   (seed_load),
      .seed        (seed),
      .rate        (rate),
      .out_ready   (out_ready),
      .out_valid   (out_valid),
      .noise       (noise),
      .lockup      (lockup),
      .busy        (busy)
`ifdef NOISE_SCHED_OVERRUN_CNT_EN
      ,
      .overrun_cnt (overrun_cnt)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   function automatic logic [13:0] nxt(input logic [13:0] s);
      logic [13:0] n;
      n = {s[12:0], ~(s[13] ^ s[12] ^ s[11] ^ s[1])};
      if (n == 14'h3FFF) n = 14'h0000;
      return n;
   endfunction

   logic [13:0] m;
   logic [13:0] first;
   logic [13:0] p;
   logic [11:0] vpat;
   int          mis_shift;
   int          mis_noise;
   int          locks;

   initial begin
      rst_n = 1'b0; en = 1'b0; seed_load = 1'b0; seed = '0; rate = '0; out_ready = 1'b1;
      tick(2);
      chk("rst_valid", out_valid, 0);
      chk("rst_noise", noise, 0);
      chk("rst_lockup", lockup, 0);
      chk("rst_busy", busy, 0);
      rst_n = 1'b1;
      tick();

      // Seed 0x0001 at rate 0
      seed = 14'h0001; en = 1'b1; seed_load = 1'b1;
      tick();
      seed_load = 1'b0;
      chk("t2_busy_load", busy, 1);
      tick();
      chk("t2_seed_vis", dut.u_lfsr.shift, 14'h0001);
      chk("t2_valid_pre", out_valid, 0);
      tick();
      chk("t2_step1", dut.u_lfsr.shift, 14'h0003);
      chk("t2_valid1", out_valid, 1);
      chk("t2_noise1", noise, 12'h000);
      tick();
      chk("t2_step2", dut.u_lfsr.shift, 14'h0006);
      chk("t2_noise2", noise, 12'h001);
      tick();
      chk("t2_step3", dut.u_lfsr.shift, 14'h000C);
      chk("t2_noise3", noise, 12'h003);
      m = 14'h000C; mis_shift = 0; mis_noise = 0; locks = 0;
      for (int i = 0; i < 16380; i++) begin
         tick();
         m = nxt(m);
         if (dut.u_lfsr.shift !== m || m == 14'h3FFF) mis_shift++;
         if (noise !== m[13:2] || out_valid !== 1'b1) mis_noise++;
         if (lockup) locks++;
      end
      chk("t2_seq_shift", mis_shift, 0);
      chk("t2_seq_noise", mis_noise, 0);
      chk("t2_seq_lockups", locks, 0);

      // Rate 3 then back to 0
      rate = 16'd3;
      tick();
      chk("t3_reload_valid", out_valid, 1);
      vpat = '0;
      for (int i = 0; i < 12; i++) begin
         rate = 16'd3;
         tick();
         vpat[i] = out_valid;
      end
      chk("t3_rate3_pat", vpat, 12'b1000_1000_1000);
      rate = 16'd0;
      vpat = '0;
      for (int i = 0; i < 8; i++) begin
         tick();
         vpat[i] = out_valid;
      end
      chk("t3_rate0_pat", vpat, 12'b0000_1111_1000);

      // All-ones seed recovers to zero
      seed = 14'h3FFF; seed_load = 1'b1;
      tick();
      seed_load = 1'b0;
      chk("t4_lock_early", lockup, 0);
      tick();
      chk("t4_lockup", lockup, 1);
      chk("t4_shift0", dut.u_lfsr.shift, 14'h0000);
      tick();
      chk("t4_lock_once", lockup, 0);
      chk("t4_continue", dut.u_lfsr.shift, 14'h0001);
      chk("t4_noise", noise, 12'h000);

      // Backpressure for 10 steps
      seed = 14'h0001; seed_load = 1'b1;
      tick();
      seed_load = 1'b0;
      tick();
      chk("t5_seed_vis", dut.u_lfsr.shift, 14'h0001);
      chk("t5_slot_empty", out_valid, 0);
      out_ready = 1'b0;
      m = 14'h0001;
      first = nxt(m);
      for (int i = 0; i < 10; i++) begin
         tick();
         m = nxt(m);
      end
      chk("t5_hold_valid", out_valid, 1);
      chk("t5_hold_noise", noise, first[13:2]);
      chk("t5_shift10", dut.u_lfsr.shift, m);
`ifdef NOISE_SCHED_OVERRUN_CNT_EN
      chk("t5_overrun9", overrun_cnt, 9);
`endif
      out_ready = 1'b1;
      tick();
      m = nxt(m);
      chk("t5_b2b_valid1", out_valid, 1);
      chk("t5_b2b_noise1", noise, m[13:2]);
      tick();
      m = nxt(m);
      chk("t5_b2b_valid2", out_valid, 1);
      chk("t5_b2b_noise2", noise, m[13:2]);

      // seed_load beats a coincident step
      seed = 14'h1234; seed_load = 1'b1;
      tick();
      seed_load = 1'b0;
      chk("t6_no_step", dut.u_lfsr.shift, m);
`ifdef NOISE_SCHED_OVERRUN_CNT_EN
      chk("t6_ovr_clear", overrun_cnt, 0);
`endif
      tick();
      chk("t6_seed_vis", dut.u_lfsr.shift, 14'h1234);

      // en=0 with a pending sample
      out_ready = 1'b0;
      tick();
      p = nxt(14'h1234);
      chk("t6_pend_valid", out_valid, 1);
      en = 1'b0;
      tick(4);
      chk("t6_idle_busy", busy, 0);
      chk("t6_frozen", dut.u_lfsr.shift, p);
      chk("t6_pend_hold", out_valid, 1);
      chk("t6_pend_noise", noise, p[13:2]);
      out_ready = 1'b1;
      tick();
      chk("t6_accepted", out_valid, 0);
      tick(2);
      chk("t6_no_more", out_valid, 0);
      chk("t6_still_frozen", dut.u_lfsr.shift, p);

      // Long stall then async reset mid-RUN
      out_ready = 1'b0; en = 1'b1;
      tick(300);
`ifdef NOISE_SCHED_OVERRUN_CNT_EN
      chk("ovr_saturate", overrun_cnt, 8'hFF);
`endif
      chk("pre_rst_valid", out_valid, 1);
      chk("pre_rst_busy", busy, 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("t1_valid", out_valid, 0);
      chk("t1_noise", noise, 0);
      chk("t1_lockup", lockup, 0);
      chk("t1_busy", busy, 0);
      chk("t1_shift", dut.u_lfsr.shift, 14'h0000);
`ifdef NOISE_SCHED_OVERRUN_CNT_EN
      chk("t1_overrun", overrun_cnt, 0);
`endif
      tick();
      rst_n = 1'b1;
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
